// File: rtl/rvsteel_bus_pkg.sv
// Shared definitions for the two-manager RISC-V Steel bus arbiter:
// FSM encoding, owner identifiers and the abort read-data pattern.
package rvsteel_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_OWN_M0 = 2'b01,
        ST_OWN_M1 = 2'b10
    } arb_state_t;

    localparam logic        OWNER_M0        = 1'b0;
    localparam logic        OWNER_M1        = 1'b1;
    localparam logic [31:0] ABORT_READ_DATA = 32'hDEADBEEF;

    function automatic logic [1:0] state_to_grant(input arb_state_t state);
        logic [1:0] grant;
        case (state)
            ST_OWN_M0: grant = 2'b01;
            ST_OWN_M1: grant = 2'b10;
            default:   grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/rvsteel_rr_select.sv
// Two-way round-robin selector: picks one requester as a one-hot grant,
// favouring the manager that did not own the bus last on a tie.
module rvsteel_rr_select
    import rvsteel_bus_pkg::*;
(
    input  logic [1:0] i_request,
    input  logic       i_last_owner,
    output logic [1:0] o_grant
);

    // Tie-break against the previous owner
    always_comb begin
        o_grant = 2'b00;
        case (i_request)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_owner == OWNER_M1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// Two-manager / one-subordinate bus arbiter with round-robin ownership.
// Optional response timeout enabled by defining RVSTEEL_ARB_TIMEOUT_EN.
module rvsteel_bus_arbiter
    import rvsteel_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] m0_rw_address,
    input  logic        m0_read_request,
    input  logic        m0_write_request,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_write_strobe,
    output logic [31:0] m0_read_data,
    output logic        m0_read_response,
    output logic        m0_write_response,

    input  logic [31:0] m1_rw_address,
    input  logic        m1_read_request,
    input  logic        m1_write_request,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_write_strobe,
    output logic [31:0] m1_read_data,
    output logic        m1_read_response,
    output logic        m1_write_response,

    output logic [31:0] s_rw_address,
    output logic [31:0] s_write_data,
    output logic [3:0]  s_write_strobe,
    output logic        s_read_request,
    output logic        s_write_request,
    input  logic [31:0] s_read_data,
    input  logic        s_read_response,
    input  logic        s_write_response,

    output logic [1:0]  grant,
    output logic        bus_timeout
);

    arb_state_t r_state;
    arb_state_t w_next_state;
    logic [1:0] r_grant;
    logic       r_last_owner;
    logic       w_next_last_owner;
    logic [1:0] w_request;
    logic [1:0] w_rr_grant;
    logic       w_s_response;
    logic       w_owner_request;
    logic       w_abort;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign w_request    = {m1_read_request | m1_write_request,
                           m0_read_request | m0_write_request};
    assign w_s_response = s_read_response | s_write_response;
    assign w_owner_request = (r_state == ST_OWN_M0) ? w_request[0] :
                             (r_state == ST_OWN_M1) ? w_request[1] : 1'b0;

    rvsteel_rr_select u_rr_select (
        .i_request    (w_request),
        .i_last_owner (r_last_owner),
        .o_grant      (w_rr_grant)
    );

`ifdef RVSTEEL_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_timeout_cnt;

    // Owned-cycle counter, zeroed during every idle cycle so it restarts at each grant
    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_timeout_cnt <= '0;
        end else begin
            r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    assign w_abort = (r_state != ST_IDLE) && w_owner_request && !w_s_response &&
                     (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_abort = 1'b0;
`endif

    assign bus_timeout = w_abort;
    assign grant       = r_grant;

    // State, grant and last-owner registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_owner <= OWNER_M1;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= state_to_grant(w_next_state);
            r_last_owner <= w_next_last_owner;
        end
    end

    // Next-state: grant from idle, release on response, dropped request or abort
    always_comb begin
        w_next_state      = r_state;
        w_next_last_owner = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_grant[0]) begin
                    w_next_state      = ST_OWN_M0;
                    w_next_last_owner = OWNER_M0;
                end else if (w_rr_grant[1]) begin
                    w_next_state      = ST_OWN_M1;
                    w_next_last_owner = OWNER_M1;
                end else begin
                    w_next_state      = ST_IDLE;
                end
            end
            ST_OWN_M0, ST_OWN_M1: begin
                if (w_s_response || !w_owner_request || w_abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request forwarding and response routing for the current owner only
    always_comb begin
        s_rw_address      = 32'h0000_0000;
        s_write_data      = 32'h0000_0000;
        s_write_strobe    = 4'b0000;
        s_read_request    = 1'b0;
        s_write_request   = 1'b0;
        m0_read_data      = 32'h0000_0000;
        m0_read_response  = 1'b0;
        m0_write_response = 1'b0;
        m1_read_data      = 32'h0000_0000;
        m1_read_response  = 1'b0;
        m1_write_response = 1'b0;
        case (r_state)
            ST_OWN_M0: begin
                s_rw_address      = m0_rw_address;
                s_write_data      = m0_write_data;
                s_write_strobe    = m0_write_strobe;
                s_read_request    = m0_read_request;
                s_write_request   = m0_write_request;
                m0_read_data      = w_abort ? ABORT_READ_DATA  : s_read_data;
                m0_read_response  = w_abort ? m0_read_request  : s_read_response;
                m0_write_response = w_abort ? m0_write_request : s_write_response;
            end
            ST_OWN_M1: begin
                s_rw_address      = m1_rw_address;
                s_write_data      = m1_write_data;
                s_write_strobe    = m1_write_strobe;
                s_read_request    = m1_read_request;
                s_write_request   = m1_write_request;
                m1_read_data      = w_abort ? ABORT_READ_DATA  : s_read_data;
                m1_read_response  = w_abort ? m1_read_request  : s_read_response;
                m1_write_response = w_abort ? m1_write_request : s_write_response;
            end
            default: begin
                s_read_request  = 1'b0;
                s_write_request = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Self-checking bench for rvsteel_bus_arbiter: directed scenarios followed by
// random traffic, all compared every cycle against a transaction-level model.
module tb_rvsteel_bus_arbiter;

    localparam int          TO    = 8;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m_addr  [2];
    logic        m_rreq  [2];
    logic        m_wreq  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_strb  [2];
    logic [31:0] o_rdata [2];
    logic        o_rresp [2];
    logic        o_wresp [2];
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_strb;
    logic        s_rreq, s_wreq, s_rresp, s_wresp;
    logic [1:0]  grant;
    logic        bus_timeout;

    int checks = 0;
    int errors = 0;

    // model: owner -1 = nobody, 0 = m0, 1 = m1
    int own  = -1;
    int last = 1;
    int cnt  = 0;
    int pulses_r [2];
    int pulses_w [2];
    int n_timeout;
    logic [31:0] last_rdata [2];

    rvsteel_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .m0_rw_address(m_addr[0]), .m0_read_request(m_rreq[0]), .m0_write_request(m_wreq[0]),
        .m0_write_data(m_wdata[0]), .m0_write_strobe(m_strb[0]),
        .m0_read_data(o_rdata[0]), .m0_read_response(o_rresp[0]), .m0_write_response(o_wresp[0]),
        .m1_rw_address(m_addr[1]), .m1_read_request(m_rreq[1]), .m1_write_request(m_wreq[1]),
        .m1_write_data(m_wdata[1]), .m1_write_strobe(m_strb[1]),
        .m1_read_data(o_rdata[1]), .m1_read_response(o_rresp[1]), .m1_write_response(o_wresp[1]),
        .s_rw_address(s_addr), .s_write_data(s_wdata), .s_write_strobe(s_strb),
        .s_read_request(s_rreq), .s_write_request(s_wreq),
        .s_read_data(s_rdata), .s_read_response(s_rresp), .s_write_response(s_wresp),
        .grant(grant), .bus_timeout(bus_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            pulses_r[i]   = 0;
            pulses_w[i]   = 0;
            last_rdata[i] = 32'h0;
        end
        n_timeout = 0;
    endtask

    // One clock: compare at negedge against the model, advance the model at posedge.
    task automatic step();
        logic [31:0] e_sa, e_sd;
        logic [3:0]  e_ss;
        logic        e_sr, e_sw, s_any, abort, oreq;
        logic [1:0]  e_g;
        logic [31:0] e_rd [2];
        logic        e_rr [2];
        logic        e_wr [2];
        @(negedge clock);
        s_any = s_rresp | s_wresp;
        abort = 1'b0;
        e_sa = 32'h0; e_sd = 32'h0; e_ss = 4'h0; e_sr = 1'b0; e_sw = 1'b0; e_g = 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_rd[i] = 32'h0; e_rr[i] = 1'b0; e_wr[i] = 1'b0;
        end
        if (own >= 0) begin
            e_g  = (own == 0) ? 2'b01 : 2'b10;
            e_sa = m_addr[own];  e_sd = m_wdata[own]; e_ss = m_strb[own];
            e_sr = m_rreq[own];  e_sw = m_wreq[own];
            e_rd[own] = s_rdata; e_rr[own] = s_rresp; e_wr[own] = s_wresp;
`ifdef RVSTEEL_ARB_TIMEOUT_EN
            if (cnt == TO - 1 && !s_any && (m_rreq[own] || m_wreq[own])) begin
                abort     = 1'b1;
                e_rd[own] = ABORT;
                e_rr[own] = m_rreq[own];
                e_wr[own] = m_wreq[own];
            end
`endif
        end
        check("grant", {30'h0, grant}, {30'h0, e_g});
        check("bus_timeout", {31'h0, bus_timeout}, {31'h0, abort});
        check("s_rw_address", s_addr, e_sa);
        check("s_write_data", s_wdata, e_sd);
        check("s_write_strobe", {28'h0, s_strb}, {28'h0, e_ss});
        check("s_read_request", {31'h0, s_rreq}, {31'h0, e_sr});
        check("s_write_request", {31'h0, s_wreq}, {31'h0, e_sw});
        for (int i = 0; i < 2; i++) begin
            check($sformatf("m%0d_read_data", i), o_rdata[i], e_rd[i]);
            check($sformatf("m%0d_read_response", i), {31'h0, o_rresp[i]}, {31'h0, e_rr[i]});
            check($sformatf("m%0d_write_response", i), {31'h0, o_wresp[i]}, {31'h0, e_wr[i]});
            if (o_rresp[i]) begin
                pulses_r[i]++;
                last_rdata[i] = o_rdata[i];
            end
            if (o_wresp[i]) pulses_w[i]++;
        end
        if (bus_timeout) n_timeout++;
        @(posedge clock);
        if (reset) begin
            own = -1; last = 1; cnt = 0;
        end else if (own < 0) begin
            if ((m_rreq[0] || m_wreq[0]) && (m_rreq[1] || m_wreq[1])) own = (last == 1) ? 0 : 1;
            else if (m_rreq[0] || m_wreq[0]) own = 0;
            else if (m_rreq[1] || m_wreq[1]) own = 1;
            if (own >= 0) begin
                last = own;
                cnt  = 0;
            end
        end else begin
            oreq = m_rreq[own] || m_wreq[own];
            if (s_any || !oreq || abort) own = -1;
            else cnt++;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 32'h0; m_rreq[i] = 1'b0; m_wreq[i] = 1'b0;
            m_wdata[i] = 32'h0; m_strb[i] = 4'h0;
        end
        s_rdata = 32'h0; s_rresp = 1'b0; s_wresp = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        step();
        reset = 1'b0;
        step();
        check("reset_grant", {30'h0, grant}, 32'h0);

        // m0 read answered after three owned cycles
        clear_counts();
        m_rreq[0] = 1'b1; m_addr[0] = 32'h0000_0100;
        step();
        step();
        step();
        s_rdata = 32'h12345678; s_rresp = 1'b1;
        step();
        s_rresp = 1'b0; s_rdata = 32'h0; m_rreq[0] = 1'b0;
        step();
        check("m0_read_pulses", pulses_r[0], 1);
        check("m0_read_value", last_rdata[0], 32'h12345678);
        check("m1_read_pulses", pulses_r[1], 0);

        // tie after reset goes to m0, then m1; a later tie with last=m0 goes to m1
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_rreq[0] = 1'b1; m_rreq[1] = 1'b1;
        step();
        check("tie1_grant", {30'h0, grant}, 32'h1);
        s_rresp = 1'b1;
        step();
        s_rresp = 1'b0; m_rreq[0] = 1'b0;
        step();
        check("tie1_second_grant", {30'h0, grant}, 32'h2);
        s_rresp = 1'b1;
        step();
        s_rresp = 1'b0; m_rreq[1] = 1'b0; m_rreq[0] = 1'b1;
        step();
        s_rresp = 1'b1;
        step();
        s_rresp = 1'b0; m_rreq[1] = 1'b1;
        step();
        check("tie2_grant", {30'h0, grant}, 32'h2);
        s_rresp = 1'b1;
        step();
        s_rresp = 1'b0; m_rreq[0] = 1'b0; m_rreq[1] = 1'b0;
        step();

        // m1 write forwarding
        clear_counts();
        m_wreq[1] = 1'b1; m_wdata[1] = 32'hCAFEF00D; m_strb[1] = 4'b0011; m_addr[1] = 32'h0000_2000;
        step();
        check("m1_write_fwd_data", s_wdata, 32'hCAFEF00D);
        check("m1_write_fwd_strobe", {28'h0, s_strb}, 32'h3);
        step();
        s_wresp = 1'b1;
        step();
        s_wresp = 1'b0; m_wreq[1] = 1'b0;
        step();
        step();
        check("m1_write_pulses", pulses_w[1], 1);

        // reset in the middle of an m1 transaction; late response is discarded
        m_rreq[1] = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check("reset_mid_grant", {30'h0, grant}, 32'h0);
        check("reset_mid_s_read_request", {31'h0, s_rreq}, 32'h0);
        clear_counts();
        reset = 1'b0; m_rreq[1] = 1'b0; s_rresp = 1'b1; s_rdata = $urandom;
        step();
        s_rresp = 1'b0;
        step();
        check("late_response_dropped", pulses_r[1], 0);

        // no subordinate response at all
        clear_counts();
        m_rreq[0] = 1'b1;
        for (int i = 0; i < TO + 3; i++) step();
`ifdef RVSTEEL_ARB_TIMEOUT_EN
        check("timeout_pulses", n_timeout, 1);
        check("timeout_read_pulses", pulses_r[0], 1);
        check("timeout_read_data", last_rdata[0], ABORT);
`else
        check("no_timeout_pulses", n_timeout, 0);
        check("held_grant", {30'h0, grant}, 32'h1);
`endif
        m_rreq[0] = 1'b0;
        step();
        step();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(3) == 0) begin
                    int k;
                    k = $urandom_range(2);
                    m_rreq[i]  = (k == 1);
                    m_wreq[i]  = (k == 2);
                    m_addr[i]  = $urandom;
                    m_wdata[i] = $urandom;
                    m_strb[i]  = 4'($urandom);
                end
            end
            s_rresp = ($urandom_range(3) == 0);
            s_wresp = ($urandom_range(3) == 0);
            s_rdata = $urandom;
            reset   = ($urandom_range(63) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
